// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: condition-select encodings, RF address width
// and the architectural flag pair.
package pipe_pkg;

    localparam int unsigned RF_AW  = 3;
    localparam int unsigned COND_W = 2;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_C      = 2'b01;
    localparam logic [1:0] COND_Z      = 2'b10;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

endpackage

// File: rtl/cc_resolve.sv
// EX-stage flag resolver: holds carry/zero, gates conditional instructions,
// tracks the deferred load zero-flag and produces the gated RF write port.
module cc_resolve #(
    parameter int unsigned RF_AW  = pipe_pkg::RF_AW,
    parameter int unsigned COND_W = pipe_pkg::COND_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [COND_W-1:0] ex_cond,
    input  logic              ex_wr_c,
    input  logic              ex_wr_z,
    input  logic              ex_is_load,
    input  logic              ex_rf_we,
    input  logic [RF_AW-1:0]  ex_rd,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              mem_zero_valid,
    input  logic              mem_zero,
    input  logic              flush,
    output logic              flag_c,
    output logic              flag_z,
    output logic              cond_ok,
    output logic              stall,
    output logic              wb_rf_we,
    output logic [RF_AW-1:0]  wb_rd
);

    import pipe_pkg::*;

    flags_t             flags_q, flags_d;
    logic               z_pend_q, z_pend_d;
    logic               wb_rf_we_q, wb_rf_we_d;
    logic [RF_AW-1:0]   wb_rd_q, wb_rd_d;
    logic               accept;
    logic               commit;

    // Condition evaluation; a zero still owed by a load cannot satisfy COND_Z.
    always_comb begin
        cond_ok = 1'b1;
        case (ex_cond)
            COND_W'(COND_ALWAYS): cond_ok = 1'b1;
            COND_W'(COND_C):      cond_ok = flags_q.c;
            COND_W'(COND_Z):      cond_ok = flags_q.z & ~z_pend_q;
            default:              cond_ok = 1'b1;
        endcase
    end

    assign stall  = ex_valid & (ex_cond == COND_W'(COND_Z)) & z_pend_q;
    assign accept = ex_valid & ~stall & ~flush;
    assign commit = accept & cond_ok;

    // Next state: MEM resolution first, then the younger EX commit overrides.
    always_comb begin
        flags_d    = flags_q;
        z_pend_d   = z_pend_q;
        wb_rf_we_d = commit & ex_rf_we;
        wb_rd_d    = wb_rd_q;

        if (mem_zero_valid && z_pend_q) begin
            flags_d.z = mem_zero;
            z_pend_d  = 1'b0;
        end

        if (commit) begin
            wb_rd_d = ex_rd;
            if (ex_wr_c) begin
                flags_d.c = alu_carry;
            end
            if (ex_wr_z && !ex_is_load) begin
                flags_d.z = alu_zero;
            end
            if (ex_wr_z && ex_is_load) begin
                z_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= '0;
            z_pend_q   <= 1'b0;
            wb_rf_we_q <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            flags_q    <= flags_d;
            z_pend_q   <= z_pend_d;
            wb_rf_we_q <= wb_rf_we_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign flag_c   = flags_q.c;
    assign flag_z   = flags_q.z;
    assign wb_rf_we = wb_rf_we_q;
    assign wb_rd    = wb_rd_q;

endmodule

// File: doc/cc_resolve.md
Name: cc_resolve

Overview:
- Execute-stage flag resolver for the 6-stage 16-bit pipeline; it sits directly upstream of the condition-code register.
- It holds the architectural carry/zero flags and decides whether a conditional ALU instruction (execute-if-carry / execute-if-zero) in EX commits.
- It tracks the deferred zero-flag update of a load, whose zero result only becomes known in MEM, and stalls dependent instructions.
- It produces the registered flag values and the gated register-file write destination consumed downstream.

Parameters:
- RF_AW, 3, register-file address width.
- COND_W, 2, width of condition-select field.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  valid instruction in EX
- ex_cond  input  COND_W  00 always, 01 if carry set, 10 if zero set, 11 treated as always
- ex_wr_c  input  1  instruction updates carry
- ex_wr_z  input  1  instruction updates zero
- ex_is_load  input  1  instruction is a load; its zero update is deferred to MEM
- ex_rf_we  input  1  instruction writes the register file
- ex_rd  input  RF_AW  destination register
- alu_carry  input  1  ALU carry out
- alu_zero  input  1  ALU zero result
- mem_zero_valid  input  1  MEM presents the zero result of the pending load
- mem_zero  input  1  zero-of-loaded-data
- flush  input  1  kill the EX instruction (branch redirect)
- flag_c  output  1  architectural carry
- flag_z  output  1  architectural zero
- cond_ok  output  1  combinational: EX instruction's condition is satisfied
- stall  output  1  combinational: hold EX and upstream stages one cycle
- wb_rf_we  output  1  registered, gated RF write enable
- wb_rd  output  RF_AW  registered destination register

Behaviour:
- Reset (synchronous, at posedge when reset=1):
  - flag_c=0, flag_z=0, wb_rf_we=0, wb_rd=0.
  - Internal z_pend=0; reset mid-operation discards any pending load-zero.
- cond_ok:
  - ex_cond=01 -> flag_c.
  - ex_cond=10 -> flag_z and !z_pend.
  - Otherwise -> 1.
- stall = ex_valid & ex_cond==10 & z_pend. stall lasts exactly one cycle for a single-cycle MEM latency.
- accept = ex_valid & !stall & !flush.
- commit = accept & cond_ok. A failed condition makes the instruction a no-op: no flag update, no RF write.
- On commit, at the posedge:
  - If ex_wr_c: flag_c <= alu_carry.
  - If ex_wr_z and !ex_is_load: flag_z <= alu_zero.
  - If ex_is_load and ex_wr_z: z_pend <= 1.
- Pending-load resolution:
  - When mem_zero_valid & z_pend: flag_z <= mem_zero and z_pend <= 0, unless a new load commits in the same cycle, in which case z_pend stays 1.
  - mem_zero_valid while z_pend=0 is ignored.
- Simultaneous events:
  - A non-load Z-writer commits in the same cycle mem_zero resolves: the EX value wins, because that instruction is younger.
  - Carry updates never conflict with load resolution.
- Downstream RF write path (one-cycle latency, registered every cycle):
  - wb_rf_we <= commit & ex_rf_we.
  - wb_rd <= ex_rd when commit, else wb_rd holds its value.
- flush overrides everything for the EX instruction (no commit, no stall effect) but does not cancel an already-pending load-zero.
- Flags are observable on flag_c/flag_z the cycle after the update edge. Back-to-back dependent ALU ops need no forwarding because flags commit at the end of EX.

Decomposition:
- Shared package pipe_pkg:
  - Localparams COND_ALWAYS=2'b00, COND_C=2'b01, COND_Z=2'b10.
  - RF_AW.
  - A typedef for the flag pair {c,z}.
- No sub-module needed. Optionally split out cc_pend_track, holding z_pend and the MEM-resolution logic, if reuse for a future deferred carry is required.

Test Plan:
- Reset with flags forced via prior ops (C=1,Z=1) -> after reset cycle flag_c=0, flag_z=0, wb_rf_we=0, wb_rd=0.
- ADD, alu_carry=1, ex_wr_c=1, ex_rd=3 -> next cycle flag_c=1, wb_rf_we=1, wb_rd=3; follow with cond=01 op rd=5 -> cond_ok=1, wb_rd=5.
- flag_z=0, cond=10 op with ex_rf_we=1 rd=2 -> cond_ok=0, no flag change, wb_rf_we=0, wb_rd unchanged.
- Load (ex_wr_z=1) then a cond=10 op next cycle with mem_zero_valid=1, mem_zero=1 -> stall=1 for one cycle. On the following cycle flag_z=1, cond_ok=1, and the op commits.
- Pending load resolves (mem_zero=1) in the same cycle a non-load Z-writer commits with alu_zero=0 -> flag_z=0.
- Load commits, then flush asserted on the next EX op while mem_zero=0 resolves -> flag_z=0, wb_rf_we=0. Separately, assert reset while z_pend=1 -> z_pend cleared and the subsequent mem_zero_valid is ignored.
